// File: rtl/relu_if.sv
// ReLU stage data bus: activation in, stage controls, registered result out.
// Latency: n/a (wiring only; the stage behind it adds one register).
// Backpressure: none; a new sample is accepted every cycle.
interface relu_if #(
    parameter int DATA_W = 16
);
    logic [DATA_W-1:0] DATA_IN;
    logic              EN_reLU;
    logic              BYPASS_reLU;
    logic [DATA_W-1:0] reLU_OUT;

    // Upstream side: drives the activation and controls, observes the result.
    modport master (
        output DATA_IN,
        output EN_reLU,
        output BYPASS_reLU,
        input  reLU_OUT
    );

    // ReLU stage side.
    modport slave (
        input  DATA_IN,
        input  EN_reLU,
        input  BYPASS_reLU,
        output reLU_OUT
    );
endinterface

// File: rtl/relu.sv
// Registered two's-complement ReLU with bypass and enable for the NPU datapath.
// Latency: 1 cycle from DATA_IN/controls to reLU_OUT.
// Backpressure: none; one sample per cycle, no handshake.
module relu #(
    parameter int DATA_W = 16
) (
    input  logic   CLKEXT,
    input  logic   RST,
    relu_if.slave  bus
);

    logic [DATA_W-1:0] out_q;
    logic [DATA_W-1:0] out_d;

    // Next value: disabled stage loads zero regardless of bypass, bypass passes
    // the input bit-exact, otherwise clamp anything with the sign bit set to zero.
    always_comb begin
        out_d = '0;
        if (bus.EN_reLU) begin
            if (bus.BYPASS_reLU) begin
                out_d = bus.DATA_IN;
            end else if (!bus.DATA_IN[DATA_W-1]) begin
                out_d = bus.DATA_IN;
            end
        end
    end

    // Single output register; synchronous reset has priority over everything.
    always_ff @(posedge CLKEXT) begin
        if (RST) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.reLU_OUT = out_q;

endmodule

// File: tb/tb_relu.sv
module tb_relu;

    localparam int DATA_W = 16;

    logic clk;
    logic rst;

    int n_checks;
    int n_fail;

    logic [DATA_W-1:0] exp_q;
    bit                have_prev;

    relu_if #(.DATA_W(DATA_W)) bus ();

    relu #(.DATA_W(DATA_W)) dut (
        .CLKEXT (clk),
        .RST    (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] got,
                         input logic [DATA_W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: reset or disable gives zero, bypass is identity, otherwise
    // negative values (as signed integers) become zero.
    function automatic logic [DATA_W-1:0] ref_relu(input bit r, input bit e, input bit b,
                                                   input logic [DATA_W-1:0] d);
        int v;
        v = int'($signed(d));
        if (r || !e) return '0;
        if (b) return d;
        if (v < 0) return '0;
        return d;
    endfunction

    // Drive one cycle of inputs; check the output holds its old value mid-cycle,
    // then check the new value just after the edge.
    task automatic apply(input string tag, input bit r, input bit e, input bit b,
                         input logic [DATA_W-1:0] d);
        rst             = r;
        bus.EN_reLU     = e;
        bus.BYPASS_reLU = b;
        bus.DATA_IN     = d;
        #2;
        if (have_prev) check({tag, "_hold"}, bus.reLU_OUT, exp_q);
        @(posedge clk);
        #1;
        exp_q     = ref_relu(r, e, b, d);
        have_prev = 1'b1;
        check(tag, bus.reLU_OUT, exp_q);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        have_prev = 1'b0;
        exp_q     = '0;

        // Reset wins over enable.
        apply("reset",        1'b1, 1'b1, 1'b0, 16'h1234);
        apply("reset_rel",    1'b0, 1'b1, 1'b0, 16'h1234);

        // Plain ReLU.
        apply("pos_1234",     1'b0, 1'b1, 1'b0, 16'd1234);
        apply("neg_ffff",     1'b0, 1'b1, 1'b0, 16'hFFFF);
        apply("zero",         1'b0, 1'b1, 1'b0, 16'h0000);
        apply("max_pos",      1'b0, 1'b1, 1'b0, 16'h7FFF);
        apply("min_neg",      1'b0, 1'b1, 1'b0, 16'h8000);

        // Bypass keeps negatives.
        apply("byp_ffff",     1'b0, 1'b1, 1'b1, 16'hFFFF);
        apply("byp_8000",     1'b0, 1'b1, 1'b1, 16'h8000);

        // Disable zeroes output regardless of bypass.
        apply("dis_byp0",     1'b0, 1'b0, 1'b0, 16'd5678);
        apply("dis_byp1",     1'b0, 1'b0, 1'b1, 16'd5678);

        // Mid-stream reset.
        apply("pre_rst",      1'b0, 1'b1, 1'b0, 16'd999);
        apply("mid_rst",      1'b1, 1'b1, 1'b1, 16'd999);
        apply("post_rst",     1'b0, 1'b1, 1'b0, 16'd4321);

        // Latency: alternating inputs each cycle.
        for (int i = 0; i < 3; i++) begin
            apply("lat_100",  1'b0, 1'b1, 1'b0, 16'd100);
            apply("lat_m5",   1'b0, 1'b1, 1'b0, 16'hFFFB);
            apply("lat_200",  1'b0, 1'b1, 1'b0, 16'd200);
        end

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            bit               r;
            bit               e;
            bit               b;
            logic [DATA_W-1:0] d;
            r = ($urandom_range(0, 19) == 0);
            e = ($urandom_range(0, 5) != 0);
            b = ($urandom_range(0, 2) == 0);
            d = DATA_W'($urandom);
            if ($urandom_range(0, 9) == 0) d = 16'h8000;
            if ($urandom_range(0, 9) == 0) d = 16'h7FFF;
            apply("rand", r, e, b, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
